// File: rtl/bcd_updown_timer_if.sv
// Signal bundle for bcd_updown_timer: control, preset and count outputs.
// The master drives the controls and the slave (the timer) drives the count outputs.
interface bcd_updown_timer_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      run;
    logic                      dir;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic                      lap;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic                      tick;
    logic                      is_zero;
    logic                      expired;
    logic                      wrap;
    logic [4*NUM_DIGITS-1:0]   lap_digits;

    modport master (
        output run, dir, load, load_value, lap,
        input  digits, tick, is_zero, expired, wrap, lap_digits
    );

    modport slave (
        input  run, dir, load, load_value, lap,
        output digits, tick, is_zero, expired, wrap, lap_digits
    );
endinterface

// File: rtl/bcd_updown_timer.sv
// Parametrised BCD up/down timer with prescaler, preset load, wrap and expiry pulses.
// Optional lap capture register is built only when TIMER_LAP_EN is defined.
module bcd_updown_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_BITS     = 26,
    parameter int MMSS         = 1,
    parameter int STOP_AT_ZERO = 1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_updown_timer_if.slave  bus
);
    localparam int W = 4 * NUM_DIGITS;

    function automatic logic [3:0] lim(input int i);
        return ((MMSS != 0) && (i % 2 == 1)) ? 4'd5 : 4'd9;
    endfunction

    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [W-1:0]        digits_q, digits_d;
    logic                tick_q, tick_d;
    logic                expired_q, expired_d;
    logic                wrap_q, wrap_d;

    logic                step;
    logic                all_zero;
    logic [W-1:0]        up_val, dn_val, load_clamped;
    logic                up_carry, dn_borrow;

    assign all_zero = (digits_q == '0);
    assign step     = bus.run && (presc_q == '1);

    // Ripple carry/borrow through the digit chain; a final carry/borrow means the count wrapped.
    always_comb begin
        up_val    = digits_q;
        dn_val    = digits_q;
        up_carry  = 1'b1;
        dn_borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (up_carry) begin
                if (digits_q[4*i +: 4] >= lim(i)) begin
                    up_val[4*i +: 4] = 4'd0;
                end else begin
                    up_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    up_carry         = 1'b0;
                end
            end
            if (dn_borrow) begin
                if (digits_q[4*i +: 4] == 4'd0) begin
                    dn_val[4*i +: 4] = lim(i);
                end else begin
                    dn_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                    dn_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clamped[4*i +: 4] = (bus.load_value[4*i +: 4] > lim(i)) ? lim(i)
                                                                          : bus.load_value[4*i +: 4];
        end
    end

    always_comb begin
        presc_d   = presc_q;
        digits_d  = digits_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        wrap_d    = 1'b0;
        if (bus.load) begin
            presc_d  = '0;
            digits_d = load_clamped;
        end else if (bus.run) begin
            // Natural overflow returns the prescaler to 0 on the step cycle.
            presc_d = presc_q + 1'b1;
            if (step) begin
                tick_d = 1'b1;
                if (bus.dir) begin
                    digits_d = up_val;
                    wrap_d   = up_carry;
                end else if (all_zero) begin
                    if (STOP_AT_ZERO == 0) begin
                        digits_d = dn_val;
                        wrap_d   = 1'b1;
                    end
                end else begin
                    digits_d  = dn_val;
                    expired_d = (dn_val == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            digits_q  <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            digits_q  <= digits_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef TIMER_LAP_EN
    logic [W-1:0] lap_q, lap_d;

    assign lap_d = bus.lap ? digits_q : lap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign bus.lap_digits = lap_q;
`else
    logic unused_lap;
    assign unused_lap     = bus.lap;
    assign bus.lap_digits = '0;
`endif

    assign bus.digits  = digits_q;
    assign bus.tick    = tick_q;
    assign bus.is_zero = all_zero;
    assign bus.expired = expired_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: doc/bcd_updown_timer.md
Name: bcd_updown_timer

Overview:
Parametrised BCD time counter, the successor to the fixed 4-digit mm:ss count-up block. Supports N digits, mm:ss or pure-decimal digit moduli, up/down direction, parallel preset load and terminal-count detection for the doomsday countdown. An internal prescaler derives the count tick from the board clock. Digit outputs feed the existing seven-segment display driver unchanged.

Parameters:
NUM_DIGITS, 4, number of BCD digits; digit 0 is least significant; must be >=1.
DIV_BITS, 26, prescaler width; one count tick every 2^DIV_BITS enabled clk cycles.
MMSS, 1, 1 = odd-index digits (1, 3, 5, ...) are tens digits that wrap at 5; 0 = every digit wraps at 9.
STOP_AT_ZERO, 1, 1 = down-count saturates at all-zero; 0 = down-count wraps to the all-maximum value.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  count enable; prescaler and digits advance only while high
dir  input  1  1 = count up, 0 = count down; sampled on the tick cycle
load  input  1  synchronous preset strobe
load_value  input  4*NUM_DIGITS  preset digits, packed; digit i at [4i+3:4i]
digits  output  4*NUM_DIGITS  current count, same packing
tick  output  1  one-cycle pulse on each count step
is_zero  output  1  high while all digits are 0 (combinational from digits)
expired  output  1  one-cycle pulse when a down-count reaches all-zero
wrap  output  1  one-cycle pulse when the count wraps past the top or bottom
lap_digits  output  4*NUM_DIGITS  captured count (see Optional Feature)
lap  input  1  capture strobe (see Optional Feature)

Behaviour:
- Reset (async): digits=0, prescaler=0, tick=0, expired=0, wrap=0, lap_digits=0.
- Digit limit: LIM(i) = 5 if MMSS=1 and i is odd, else 9.
- Prescaler: increments each clk while run=1 and load=0; holds its value while run=0.
- Internal step is asserted in the cycle the prescaler equals all-ones; the prescaler rolls to 0 in that cycle.
- The tick output is registered: it is high in the cycle after step, coincident with the updated digits.
- Up step: digit 0 increments. A digit at LIM(i) goes to 0 and carries into digit i+1.
- Up wrap: if all digits are at their limits, the result is all-zero and wrap pulses.
- Down step: digit 0 decrements. A digit at 0 goes to LIM(i) and borrows from digit i+1.
- Down step from nonzero to all-zero: expired pulses (registered, same cycle as tick).
- Down step while already all-zero, STOP_AT_ZERO=1: digits hold and no pulses fire; tick still pulses.
- Down step while already all-zero, STOP_AT_ZERO=0: digits become all-LIM and wrap pulses.
- Load:
  - Highest priority; the count updates on the next clk edge and the prescaler clears to 0.
  - A load_value digit above LIM(i) is clamped to LIM(i).
  - Load pulses no tick, expired or wrap; a step that coincides with load is discarded.
- dir change mid-run: takes effect on the next step; there is no extra latency.
- Reset mid-operation: outputs return immediately to reset values; the prescaler restarts from 0.
- Only registered values 0..LIM(i) ever appear on each digit.

Optional Feature:
Macro TIMER_LAP_EN.
- Defined: a lap pulse copies the current digits into lap_digits on the next edge.
  - If lap coincides with a step, the pre-step value is captured.
  - lap_digits holds until the next lap or reset.
- Undefined: the lap input is ignored, lap_digits is tied to 0 and no capture register is built.

Test Plan:
- Tick cadence. DIV_BITS=2, NUM_DIGITS=4, MMSS=1, run=1, dir=1 from reset -> tick every 4th cycle; digits 0000 -> 0001 on the first tick.
- Up carry chain. Load 0959, dir=1, run=1 -> next tick gives 1000. Load 5959, run -> next tick gives 0000 with wrap=1 for one cycle.
- Down borrow and expiry. Load 1000, dir=0, run -> 0959. Load 0001 -> next tick gives 0000 with expired=1. Further ticks hold 0000 with no pulses, and is_zero stays high.
- STOP_AT_ZERO=0, digits 0000, dir=0 -> next tick gives 5959 with wrap=1. With MMSS=0 the same step gives 9999.
- Load clamp and priority. load_value=7A9F with MMSS=1 -> digits 5959. Load asserted on a step cycle -> load value wins, no tick pulse, prescaler restarts.
- run=0 for 10 cycles mid-prescale -> digits and prescaler frozen. Async reset pulse mid-count -> digits 0000 immediately. With TIMER_LAP_EN, lap at 0123 -> lap_digits=0123 while digits continue.
